fifo_uart_tx: RTL and testbench

Drain side of the AD sample buffer. Pops 12-bit samples from the sample FIFO and serialises each one as a framed pair of UART bytes (8N1, LSB first) on the `tx` pin toward the host PC. It sits between the FIFO read port and the board UART pin, runs on the 50 MHz system clock, and replaces the ad_done-driven UART path. It only pops when it is idle, so the FIFO absorbs burst acquisition while the serial line paces readout.

---
 rtl/fifo_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Purpose: pops 12-bit samples from a show-ahead FIFO and sends each as framed 8N1 UART bytes (hdr|hi, lo[, xor]).
// Latency: 3 cycles from an idle cycle with data available to the tx start bit; one sample takes 3 + NBYTES*10*BAUD_DIV cycles.
// Backpressure: pops only while idle with enable high and FIFO non-empty; the serial line paces readout. Macro FIFO_UART_TX_CHECKSUM_EN adds an XOR byte.
module fifo_uart_tx #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         BAUD       = 115200,
    parameter int         BAUD_DIV   = CLK_FREQ / BAUD,  // cycles per bit, must be >= 4
    parameter logic [3:0] HDR_NIBBLE = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_rd_data,
    input  logic        fifo_rd_valid,
    output logic        fifo_rd_req,
    output logic        tx,
    output logic        busy,
    output logic        sample_done
);

    localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
`ifdef FIFO_UART_TX_CHECKSUM_EN
    localparam logic [1:0]     LAST_BYTE = 2'd2;
`else
    localparam logic [1:0]     LAST_BYTE = 2'd1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [1:0]    byte_idx, byte_nxt;
    logic [11:0]   sample_reg, sample_nxt;
    logic          tx_nxt;
    logic          req_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic [7:0]    cur_byte;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // Byte currently on the wire, derived from the held sample and the byte index.
    always_comb begin
        cur_byte = {HDR_NIBBLE, sample_reg[11:8]};
        case (byte_idx)
            2'd1:    cur_byte = sample_reg[7:0];
`ifdef FIFO_UART_TX_CHECKSUM_EN
            2'd2:    cur_byte = {HDR_NIBBLE, sample_reg[11:8]} ^ sample_reg[7:0];
`endif
            default: cur_byte = {HDR_NIBBLE, sample_reg[11:8]};
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            sample_reg  <= '0;
            tx          <= 1'b1;
            fifo_rd_req <= 1'b0;
            busy        <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_nxt;
            bit_cnt     <= bit_nxt;
            byte_idx    <= byte_nxt;
            sample_reg  <= sample_nxt;
            tx          <= tx_nxt;
            fifo_rd_req <= req_nxt;
            busy        <= busy_nxt;
            sample_done <= done_nxt;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_cnt;
        byte_nxt   = byte_idx;
        sample_nxt = sample_reg;
        tx_nxt     = tx;
        req_nxt    = 1'b0;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            REQ: begin
                // Head word is valid while the request is high; capture it now.
                sample_nxt = fifo_rd_data;
                state_nxt  = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (fifo_rd_valid) begin
                    byte_nxt  = 2'd0;
                    baud_nxt  = '0;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end else begin
                    // FIFO ran dry under us: the captured word is not real data.
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    tx_nxt    = cur_byte[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        tx_nxt  = cur_byte[bit_cnt + 3'd1];
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (byte_idx != LAST_BYTE) begin
                        // Next byte starts straight after this stop bit, no idle gap.
                        byte_nxt  = byte_idx + 2'd1;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLK_FREQ=1000, BAUD=100 (10 cycles per bit).
// A behavioural FIFO feeds the DUT; a line decoder recovers bytes from tx.
// Build with FIFO_UART_TX_CHECKSUM_EN defined to exercise the three-byte frame.
module tb_fifo_uart_tx;

    localparam int BD = 10;
`ifdef FIFO_UART_TX_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int SP = 3 + NB * 10 * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [11:0] fifo_rd_data = '0;
    logic        fifo_rd_valid = 1'b0;
    logic        fifo_rd_req;
    logic        tx;
    logic        busy;
    logic        sample_done;

    fifo_uart_tx #(
        .CLK_FREQ(1000),
        .BAUD(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid),
        .fifo_rd_req(fifo_rd_req),
        .tx(tx),
        .busy(busy),
        .sample_done(sample_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] sample;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;
    vec_t tbl[5];

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] fifo_q[$];
    bit          drop_ack = 1'b0;

    logic [7:0] rx_q[$];
    int fall_q[$];
    int req_cyc_q[$];
    int done_cyc_q[$];
    int req_cnt = 0;
    int done_cnt = 0;
    int req_viol = 0;
    int frame_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int rxget(input int i);
        if (i < rx_q.size()) return int'(rx_q[i]);
        return -1;
    endfunction

    function automatic int tbl_byte(input int i, input int j);
        if (j == 0) return int'(tbl[i].b0);
        if (j == 1) return int'(tbl[i].b1);
        return int'(tbl[i].b2);
    endfunction

    task automatic fifo_upd();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() == 0) ? 12'h000 : fifo_q[0];
    endtask

    task automatic push(input logic [11:0] s);
        fifo_q.push_back(s);
        fifo_upd();
    endtask

    task automatic clear_mon();
        rx_q.delete();
        fall_q.delete();
        req_cyc_q.delete();
        done_cyc_q.delete();
        req_cnt   = 0;
        done_cnt  = 0;
        frame_err = 0;
    endtask

    task automatic wait_drain(input int max, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((fifo_q.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " drain within budget"}, int'(n < max), 1);
        repeat (5) @(negedge clk);
    endtask

    // Show-ahead FIFO: a request seen during a cycle pops at the following edge and acknowledges for one cycle.
    initial begin : fifo_model
        logic req_seen;
        forever begin
            @(negedge clk);
            req_seen = fifo_rd_req;
            @(posedge clk);
            #1;
            if (req_seen === 1'b1 && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                fifo_rd_valid = !drop_ack;
            end else begin
                fifo_rd_valid = 1'b0;
            end
            fifo_upd();
        end
    end

    // Request and done pulse monitor.
    initial begin : pulse_mon
        logic req_prev;
        logic empty_prev;
        req_prev   = 1'b0;
        empty_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (fifo_rd_req === 1'b1) begin
                req_cnt++;
                req_cyc_q.push_back(cyc);
                if (req_prev === 1'b1) req_viol++;
                if (empty_prev === 1'b1) req_viol++;
            end
            if (sample_done === 1'b1) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            req_prev   = fifo_rd_req;
            empty_prev = fifo_empty;
        end
    end

    // UART receiver: every bit cell must hold its level for all BD cycles.
    initial begin : line_decoder
        logic [9:0] frame;
        bit         uni;
        logic       tx_prev;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
                fall_q.push_back(cyc);
                uni   = 1'b1;
                frame = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BD; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) frame[b] = tx;
                        else if (tx !== frame[b]) uni = 1'b0;
                    end
                end
                rx_q.push_back(frame[8:1]);
                if (!uni || frame[0] !== 1'b0 || frame[9] !== 1'b1) frame_err++;
            end
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int t0;
        int gap;
        logic [11:0] s;
        logic [7:0] e0, e1;
        logic [7:0] exp_q[$];

        tbl[0] = '{12'h5C3, 8'hA5, 8'hC3, 8'h66};
        tbl[1] = '{12'h000, 8'hA0, 8'h00, 8'hA0};
        tbl[2] = '{12'hFFF, 8'hAF, 8'hFF, 8'h50};
        tbl[3] = '{12'h123, 8'hA1, 8'h23, 8'h82};
        tbl[4] = '{12'hA5A, 8'hAA, 8'h5A, 8'hF0};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx", int'(tx), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset rd_req", int'(fifo_rd_req), 0);
        chk("reset sample_done", int'(sample_done), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // Idle with an empty FIFO.
        clear_mon();
        repeat (500) @(negedge clk);
        chk("idle tx falls", fall_q.size(), 0);
        chk("idle rd_req count", req_cnt, 0);
        chk("idle busy", int'(busy), 0);
        chk("idle tx", int'(tx), 1);

        // Single sample: exact timing of request, start bit and done.
        clear_mon();
        @(posedge clk); #1;
        t0 = cyc;
        push(tbl[0].sample);
        wait_drain(2000, "single");
        chk("single rd_req count", req_cnt, 1);
        chk("single rd_req cycle", qget(req_cyc_q, 0) - t0, 1);
        chk("single tx fall cycle", qget(fall_q, 0) - t0, 3);
        chk("single byte count", rx_q.size(), NB);
        for (int j = 0; j < NB; j++) chk($sformatf("single byte%0d", j), rxget(j), tbl_byte(0, j));
        chk("single done count", done_cnt, 1);
        chk("single done cycle", qget(done_cyc_q, 0) - t0, SP);
        chk("single framing", frame_err, 0);

        // Three samples queued at once: byte content and one idle cycle between samples.
        clear_mon();
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 1; k <= 3; k++) push(tbl[k].sample);
        wait_drain(3000, "burst");
        chk("burst rd_req count", req_cnt, 3);
        chk("burst byte count", rx_q.size(), 3 * NB);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < NB; j++)
                chk($sformatf("burst s%0d byte%0d", k, j), rxget(k * NB + j), tbl_byte(k + 1, j));
            chk($sformatf("burst s%0d fall", k), qget(fall_q, k * NB) - t0, 3 + k * SP);
            chk($sformatf("burst s%0d done", k), qget(done_cyc_q, k) - t0, (k + 1) * SP);
        end
        chk("burst framing", frame_err, 0);

        // enable dropped mid-DATA: current sample completes, nothing else popped.
        clear_mon();
        @(posedge clk); #1;
        push(tbl[2].sample);
        push(tbl[3].sample);
        repeat (40) @(posedge clk);
        #1 enable = 1'b0;
        repeat (SP + 100) @(negedge clk);
        chk("endrop rd_req count", req_cnt, 1);
        chk("endrop byte count", rx_q.size(), NB);
        for (int j = 0; j < NB; j++) chk($sformatf("endrop byte%0d", j), rxget(j), tbl_byte(2, j));
        chk("endrop tx", int'(tx), 1);
        chk("endrop busy", int'(busy), 0);
        chk("endrop fifo left", fifo_q.size(), 1);
        @(posedge clk); #1 enable = 1'b1;
        wait_drain(2000, "endrop resume");
        chk("endrop resume bytes", rx_q.size(), 2 * NB);
        chk("endrop resume byte0", rxget(NB), tbl_byte(3, 0));

        // Asynchronous reset mid-DATA, then a clean sample after release.
        clear_mon();
        @(posedge clk); #1;
        push(tbl[4].sample);
        push(tbl[0].sample);
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset tx", int'(tx), 1);
        chk("async reset busy", int'(busy), 0);
        repeat (150) @(posedge clk);
        #1;
        clear_mon();
        rst_n = 1'b1;
        t0 = cyc;
        wait_drain(2000, "post-reset");
        chk("post-reset rd_req count", req_cnt, 1);
        chk("post-reset fall cycle", qget(fall_q, 0) - t0, 3);
        for (int j = 0; j < NB; j++) chk($sformatf("post-reset byte%0d", j), rxget(j), tbl_byte(0, j));
        chk("post-reset framing", frame_err, 0);

        // Empty race: pop not acknowledged, sample dropped, back to idle.
        clear_mon();
        drop_ack = 1'b1;
        @(posedge clk); #1;
        push(12'h777);
        @(negedge clk);
        @(negedge clk);
        chk("race busy in REQ", int'(busy), 1);
        @(negedge clk);
        chk("race busy in WAIT_ACK", int'(busy), 1);
        @(negedge clk);
        chk("race busy after drop", int'(busy), 0);
        repeat (50) @(negedge clk);
        drop_ack = 1'b0;
        chk("race rd_req count", req_cnt, 1);
        chk("race tx falls", fall_q.size(), 0);
        chk("race tx", int'(tx), 1);
        chk("race fifo empty", fifo_q.size(), 0);

        // Randomized samples, gaps and enable toggles against the byte-stream model.
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            s = 12'($urandom_range(0, 4095));
            @(posedge clk); #1;
            push(s);
            e0 = 8'(32'hA0 + 32'(s >> 8));
            e1 = 8'(s & 12'h0FF);
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            if (NB == 3) exp_q.push_back(e0 ^ e1);
            gap = $urandom_range(0, 260);
            repeat (gap) @(posedge clk);
            #1 enable = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 enable = 1'b1;
        wait_drain(20000, "random");
        chk("random byte count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("random byte %0d", i), rxget(i), int'(exp_q[i]));
        chk("random rd_req count", req_cnt, 12);
        chk("random done count", done_cnt, 12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("random s%0d gapless bytes", k),
                qget(fall_q, k * NB + NB - 1) - qget(fall_q, k * NB), (NB - 1) * 10 * BD);
            chk($sformatf("random s%0d done offset", k),
                qget(done_cyc_q, k) - qget(fall_q, k * NB), NB * 10 * BD);
            if (k < 11)
                chk($sformatf("random s%0d spacing", k),
                    int'(qget(fall_q, (k + 1) * NB) - qget(fall_q, k * NB) >= SP), 1);
        end
        chk("random framing", frame_err, 0);
        chk("rd_req protocol violations", req_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
